// File: rtl/ula_pkg.sv
// Shared ALU/mult-div definitions.
// Holds the 4-bit ULAopcode encodings produced by ALU control and the
// state encoding of the iterative multiply/divide FSM.
package ula_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_MULT = 4'b1000;
  localparam logic [3:0] OP_DIV  = 4'b1001;
  localparam logic [3:0] OP_MFLO = 4'b1010;
  localparam logic [3:0] OP_MFHI = 4'b1011;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_XOR  = 4'b1101;
  localparam logic [3:0] OP_LUI  = 4'b1110;

  // state   | meaning
  // ST_IDLE | waiting for a MULT/DIV start
  // ST_CALC | one radix-2 step per cycle, WIDTH cycles
  // ST_FIX  | sign correction, HI/LO written on the edge leaving
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2
  } mdu_state_t;

endpackage

// File: rtl/ula_multdiv.sv
// Iterative multiply/divide unit beside the single-cycle ALU.
// MULT: shift-add into a 2*WIDTH accumulator, {hi,lo} = product.
// DIV : restoring shift-subtract, lo = quotient, hi = remainder.
// Ports:
//   clock, reset (async, active-high)
//   start, ULAopcode, Unsigned, A, B : request and operands
//   busy, done, div_zero             : status (done/div_zero one-cycle pulses)
//   hi, lo                           : result registers
//   Resultado                        : MFLO/MFHI read mux, 0 for other opcodes
module ula_multdiv
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       ULAopcode,
  input  logic             Unsigned,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] Resultado
);

  localparam int CW = $clog2(WIDTH);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return ~v + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return ~v + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  mdu_state_t r_state, w_next;

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;     // multiplicand (MULT) or divisor magnitude (DIV)
  logic [WIDTH-1:0]   r_a_raw;    // dividend as latched, returned in hi on divide by zero
  logic [CW-1:0]      r_counter;
  logic               r_is_div;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div_zero;

  logic               w_accept;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;
  logic [WIDTH-1:0]   w_quot, w_rem;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start && (ULAopcode == OP_MULT || ULAopcode == OP_DIV)) begin
          w_accept = 1'b1;
          w_next   = ST_CALC;
        end
      end
      ST_CALC: if (r_counter == '0) w_next = ST_FIX;
      ST_FIX:  w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign busy = (r_state != ST_IDLE);

  // Operand magnitudes at acceptance
  assign w_a_neg = ~Unsigned & A[WIDTH-1];
  assign w_b_neg = ~Unsigned & B[WIDTH-1];
  assign w_a_mag = w_a_neg ? neg_w(A) : A;
  assign w_b_mag = w_b_neg ? neg_w(B) : B;

  // Multiply step: add multiplicand into the upper half when LSB set, then shift right
  assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
  assign w_mul_next = r_acc[0] ? {w_sum, r_acc[WIDTH-1:1]} : {1'b0, r_acc[2*WIDTH-1:1]};

  // Divide step: shift {rem,quot} left, trial-subtract divisor; bit WIDTH of
  // the difference is the borrow because the shifted remainder is < 2*divisor.
  assign w_rem_sh   = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_diff     = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = !w_diff[WIDTH] ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                                     : {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_res ? neg_2w(r_acc) : r_acc;
  assign w_quot = r_neg_res ? neg_w(r_acc[WIDTH-1:0]) : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_rem ? neg_w(r_acc[2*WIDTH-1:WIDTH]) : r_acc[2*WIDTH-1:WIDTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_acc      <= '0;
      r_opnd     <= '0;
      r_a_raw    <= '0;
      r_counter  <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_div_zero <= 1'b0;
      hi         <= '0;
      lo         <= '0;
      done       <= 1'b0;
      div_zero   <= 1'b0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      if (w_accept) begin
        r_is_div   <= (ULAopcode == OP_DIV);
        r_neg_res  <= w_a_neg ^ w_b_neg;
        r_neg_rem  <= w_a_neg;
        r_div_zero <= (ULAopcode == OP_DIV) && (B == '0);
        r_a_raw    <= A;
        r_counter  <= CW'(WIDTH-1);
        if (ULAopcode == OP_DIV) begin
          r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
          r_opnd <= w_b_mag;
        end else begin
          r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
          r_opnd <= w_a_mag;
        end
      end else if (r_state == ST_CALC) begin
        r_acc <= r_is_div ? w_div_next : w_mul_next;
        if (r_counter != '0) r_counter <= r_counter - CW'(1);
      end else if (r_state == ST_FIX) begin
        done     <= 1'b1;
        div_zero <= r_div_zero;
        if (!r_is_div) begin
          hi <= w_prod[2*WIDTH-1:WIDTH];
          lo <= w_prod[WIDTH-1:0];
        end else if (r_div_zero) begin
          hi <= r_a_raw;
          lo <= '1;
        end else begin
          hi <= w_rem;
          lo <= w_quot;
        end
      end
    end
  end

  always_comb begin
    Resultado = '0;
    case (ULAopcode)
      OP_MFLO: Resultado = lo;
      OP_MFHI: Resultado = hi;
      default: Resultado = '0;
    endcase
  end

endmodule

// File: tb/tb_ula_multdiv.sv
module tb_ula_multdiv;
  import ula_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  ULAopcode;
  logic        Unsigned;
  logic [31:0] A, B;
  logic        busy, done, div_zero;
  logic [31:0] hi, lo, Resultado;

  int n_cmp  = 0;
  int n_fail = 0;
  int lat;
  bit seen_done;

  ula_multdiv #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .ULAopcode(ULAopcode),
    .Unsigned(Unsigned), .A(A), .B(B), .busy(busy), .done(done),
    .div_zero(div_zero), .hi(hi), .lo(lo), .Resultado(Resultado)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Caller is #1 after an edge; start is accepted on the next edge (E0).
  // lat = number of edges after E0 until done is seen high, -1 on timeout.
  task automatic run_op(input logic [3:0] op, input logic u, input logic [31:0] a, input logic [31:0] b,
                        output int l);
    ULAopcode = op; Unsigned = u; A = a; B = b; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    l = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clock); #1;
      if (done) begin l = n; break; end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; ULAopcode = OP_ADD; Unsigned = 1'b0; A = '0; B = '0;
    @(posedge clock); #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_dz",   {63'd0, div_zero}, 64'd0);
    chk("rst_hi",   {32'd0, hi}, 64'd0);
    chk("rst_lo",   {32'd0, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clock); #1;

    // signed 7 * -3 = -21
    run_op(OP_MULT, 1'b0, 32'd7, 32'hFFFFFFFD, lat);
    chk("mul_s_lat",  64'(lat), 64'd33);
    chk("mul_s_busy", {63'd0, busy}, 64'd0);
    chk("mul_s_hi",   {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    chk("mul_s_lo",   {32'd0, lo}, 64'h0000_0000_FFFF_FFEB);
    ULAopcode = OP_MFLO; #1;
    chk("mul_s_mflo", {32'd0, Resultado}, 64'h0000_0000_FFFF_FFEB);
    @(posedge clock); #1;
    chk("mul_s_done_pulse", {63'd0, done}, 64'd0);

    // unsigned max * max
    run_op(OP_MULT, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, lat);
    chk("mul_u_lat", 64'(lat), 64'd33);
    chk("mul_u_hi",  {32'd0, hi}, 64'h0000_0000_FFFF_FFFE);
    chk("mul_u_lo",  {32'd0, lo}, 64'd1);

    // signed -7 / 2 = -3 rem -1
    run_op(OP_DIV, 1'b0, 32'hFFFFFFF9, 32'd2, lat);
    chk("div_s_lat", 64'(lat), 64'd33);
    chk("div_s_lo",  {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    chk("div_s_hi",  {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    ULAopcode = OP_MFHI; #1;
    chk("div_s_mfhi", {32'd0, Resultado}, 64'h0000_0000_FFFF_FFFF);
    ULAopcode = OP_ADD; #1;
    chk("res_other_op", {32'd0, Resultado}, 64'd0);

    // signed overflow -2^31 / -1
    run_op(OP_DIV, 1'b0, 32'h80000000, 32'hFFFFFFFF, lat);
    chk("div_ovf_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    chk("div_ovf_hi", {32'd0, hi}, 64'd0);
    chk("div_ovf_dz", {63'd0, div_zero}, 64'd0);

    // divide by zero
    run_op(OP_DIV, 1'b0, 32'd5, 32'd0, lat);
    chk("div0_lat", 64'(lat), 64'd33);
    chk("div0_lo",  {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    chk("div0_hi",  {32'd0, hi}, 64'd5);
    chk("div0_dz",  {63'd0, div_zero}, 64'd1);
    @(posedge clock); #1;
    chk("div0_dz_pulse", {63'd0, div_zero}, 64'd0);

    // MULT 3*4 with a DIV start and operand churn mid-run
    ULAopcode = OP_MULT; Unsigned = 1'b1; A = 32'd3; B = 32'd4; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      if (n == 5) begin
        start = 1'b1; ULAopcode = OP_DIV; A = 32'd100; B = 32'd7;
      end else if (n > 5 && n < 12) begin
        A = ~A; B = ~B; Unsigned = ~Unsigned;
      end else if (n == 12) begin
        start = 1'b0;
      end
      @(posedge clock); #1;
      if (done) begin lat = n; break; end
    end
    chk("busy_ign_lat", 64'(lat), 64'd33);
    chk("busy_ign_lo",  {32'd0, lo}, 64'd12);
    chk("busy_ign_hi",  {32'd0, hi}, 64'd0);

    // back-to-back start in the done cycle: 100 / 7 = 14 rem 2
    run_op(OP_DIV, 1'b1, 32'd100, 32'd7, lat);
    chk("b2b_lat", 64'(lat), 64'd33);
    chk("b2b_lo",  {32'd0, lo}, 64'd14);
    chk("b2b_hi",  {32'd0, hi}, 64'd2);

    // async reset mid-DIV
    ULAopcode = OP_DIV; Unsigned = 1'b1; A = 32'd1000; B = 32'd3; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_done", {63'd0, done}, 64'd0);
    chk("arst_hi",   {32'd0, hi}, 64'd0);
    chk("arst_lo",   {32'd0, lo}, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    seen_done = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clock); #1;
      if (done) seen_done = 1'b1;
    end
    chk("arst_no_done", {63'd0, seen_done}, 64'd0);

    // non-MULT/DIV opcode with start is ignored
    ULAopcode = OP_ADD; A = 32'd1; B = 32'd2; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    chk("ign_op_busy", {63'd0, busy}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ula_multdiv.md
Name: ula_multdiv

Overview:
Iterative multiply/divide unit that consumes the 4-bit ULAopcode, Unsigned flag and operands produced by the ALU-control path. It executes MULT (4'b1000) and DIV (4'b1001) over multiple cycles into HI/LO registers, and serves MFLO (4'b1010) and MFHI (4'b1011) reads. It sits beside the single-cycle ALU; the core stalls on busy.

Parameters:
WIDTH, 32, operand/HI/LO width; the iteration count equals WIDTH.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request strobe; sampled only when busy=0.
ULAopcode  input  4  operation code from ALU control.
Unsigned  input  1  1 = unsigned operands, 0 = two's-complement.
A  input  WIDTH  multiplicand / dividend.
B  input  WIDTH  multiplier / divisor.
busy  output  1  high while an operation is in flight.
done  output  1  one-cycle pulse; HI/LO already hold the new result.
div_zero  output  1  pulses with done when the DIV divisor was 0.
hi  output  WIDTH  HI register.
lo  output  WIDTH  LO register.
Resultado  output  WIDTH  combinational read mux: lo for 1010, hi for 1011, 0 otherwise.

Behaviour:
- One clock domain. Asynchronous active-high reset forces: state=IDLE, hi=0, lo=0, busy=0, done=0, div_zero=0, counter=0.
- FSM states: IDLE, CALC, FIX.
- IDLE: if start=1 and ULAopcode is 1000 or 1001, the unit latches A, B, Unsigned and the op.
  - If signed, it converts operands to magnitudes and records the result signs.
  - It loads counter=WIDTH-1 and goes to CALC.
  - Any other opcode with start is ignored; the unit stays in IDLE.
- CALC: performs one radix-2 step per cycle.
  - MULT uses shift-add into a 2*WIDTH accumulator.
  - DIV uses restoring shift-subtract.
  - When counter==0 the unit goes to FIX; otherwise it decrements the counter.
  - CALC lasts exactly WIDTH cycles.
- FIX: applies sign correction, writes hi/lo on the edge leaving FIX, then returns to IDLE.
- done and div_zero are registered and go high in the cycle immediately after that edge.
- Latency: start accepted at edge E0 -> hi/lo updated at edge E(WIDTH+1) -> done high for cycle E(WIDTH+1)..E(WIDTH+2).
- busy is high from E0 to E(WIDTH+1) and is low during the done cycle. A new start may be accepted in the done cycle.
- MULT result: {hi,lo} = the full 2*WIDTH product. When signed, the product is negated if the operand signs differ.
- DIV result: lo = quotient, hi = remainder.
  - Signed: the quotient is negated if the signs differ; the remainder takes the sign of the dividend (truncating division).
- Divide by zero: the full WIDTH cycles still elapse, with lo = all ones and hi = dividend (A as latched, unmodified). div_zero=1 with done.
- Signed overflow (-2^(WIDTH-1) / -1): lo = 0x80000000, hi = 0, no flag.
- start while busy: ignored; latched operands and progress are not disturbed.
- Input changes after acceptance have no effect on the result.
- Reset mid-operation aborts immediately to the reset values; no done pulse is produced.
- MFLO/MFHI read hi/lo through Resultado combinationally at all times. While busy, they return the previous values; stalling is the core's job.

Decomposition:
- Shared package ula_pkg holds the 4-bit opcode constants: OP_AND=0000, OP_OR=0001, OP_ADD=0010, OP_SLL=0011, OP_SRL=0100, OP_SUB=0110, OP_SLT=0111, OP_MULT=1000, OP_DIV=1001, OP_MFLO=1010, OP_MFHI=1011, OP_NOR=1100, OP_XOR=1101, OP_LUI=1110.
- The package also holds the FSM state encoding.
- No sub-module: a single FSM plus datapath, with a local function for two's-complement negation.

Test Plan:
- MULT signed, A=7, B=0xFFFFFFFD (-3) -> done at cycle 33 after accept; hi=0xFFFFFFFF, lo=0xFFFFFFEB; Resultado with 1010 = 0xFFFFFFEB.
- MULT Unsigned=1, A=B=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV signed, A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0, div_zero=0.
- DIV A=5, B=0 -> lo=0xFFFFFFFF, hi=5, div_zero=1 pulsed for exactly one cycle with done.
- MULT 3*4 accepted, then start with DIV 100/7 at cycle 5 and A/B toggled mid-run -> second start ignored; lo=12, hi=0. Back-to-back start in the done cycle is accepted.
- Reset asserted asynchronously at cycle 10 of a DIV -> busy, done, hi, lo drop to 0 immediately; no done pulse follows. start with ULAopcode=0010 -> busy stays 0.
